vga_box_gen: RTL and testbench
==============================

// Module: vga_box_gen
// PURPOSE
//  Pixel generator stage fed directly by vga_sync (pix_x/pix_y/hsync/vsync).
//  Draws a solid square on a background colour. The square moves once per frame
//  and bounces off the visible-area edges.
//  Outputs registered RGB plus hsync/vsync delayed one clock, so colour and sync stay aligned at the VGA connector.
// PARAMETERS
//  H_VIS      640     visible pixels per line
//  V_VIS      480     visible lines per frame
//  BOX_SIZE   32      square side, pixels
//  STEP       2       pixels moved per frame, per axis
//  BOX_COLOR  3'b100  square colour (RGB)
//  BG_COLOR   3'b001  background colour (RGB)
//  GRID_COLOR 3'b010  grid colour (used only with GRID_OVERLAY_EN)
// PORTS
//  clk         in   1   system clock (same clock as vga_sync)
//  reset       in   1   synchronous, active-high reset
//  run         in   1   1 = box moves on frame tick; 0 = box frozen
//  hsync_in    in   1   hsync from vga_sync
//  vsync_in    in   1   vsync from vga_sync
//  pix_x       in   10  current pixel column from vga_sync
//  pix_y       in   10  current pixel row from vga_sync
//  hsync       out  1   hsync_in delayed 1 clk
//  vsync       out  1   vsync_in delayed 1 clk
//  rgb         out  3   registered pixel colour
//  frame_tick  out  1   1-clk pulse at start of vertical blanking
// BEHAVIOUR
//  - All state changes on posedge clk. Reset is synchronous, active-high:
//    hsync=0, vsync=0, rgb=0, frame_tick=0, box_x=0, box_y=0, dir_x=+, dir_y=+, tick_d=0.
//  - video_on = (pix_x < H_VIS) && (pix_y < V_VIS). This is computed combinationally inside the block.
//  - Frame tick:
//    - tick_c = (pix_y == V_VIS).
//    - tick_d <= tick_c.
//    - frame_tick <= tick_c & ~tick_d.
//    - Result: exactly one pulse per frame, even though pix_x advances every 2 clk.
//  - Motion is evaluated only in the cycle when frame_tick==1 and run==1.
//    - Arithmetic is done in 11 bits, so no 10-bit wrap is possible.
//  - Moving in the + direction: nx = box_x + STEP.
//    - If nx >= H_VIS - BOX_SIZE: box_x <= H_VIS - BOX_SIZE and dir_x <= -.
//    - Otherwise: box_x <= nx.
//  - Moving in the - direction:
//    - If box_x <= STEP: box_x <= 0 and dir_x <= +.
//    - Otherwise: box_x <= box_x - STEP.
//  - The Y axis follows the same rules with V_VIS, box_y and dir_y. X and Y update in the same cycle, independently.
//    A corner hit flips both directions.
//  - run==0: box_x, box_y, dir_x and dir_y hold their values; frame_tick still pulses.
//  - Pixel pipeline (latency 1 clk from pix_x/pix_y/hsync_in/vsync_in to outputs):
//    - in_box = (box_x <= pix_x < box_x+BOX_SIZE) && (box_y <= pix_y < box_y+BOX_SIZE).
//    - rgb <= !video_on ? 3'b000 : in_box ? BOX_COLOR : BG_COLOR.
//    - hsync <= hsync_in; vsync <= vsync_in.
//  - Box position is only updated during vertical blanking, so the visible frame never tears.
//  - Reset mid-frame: the next clk drives all outputs to their reset values. Normal operation resumes on the following clk,
//    with the box at (0,0) and moving +X/+Y.
// CONFIGURATION
//  - GRID_OVERLAY_EN defined:
//    - Inside video_on and outside the box, pixels with pix_x[4:0]==0 or pix_y[4:0]==0 show GRID_COLOR.
//    - Priority: blank > box > grid > background.
//  - GRID_OVERLAY_EN undefined: no grid logic is synthesised; rgb follows the base rules only.
// TESTING
//  1. reset=1 for 5 clk, pix_x=100, pix_y=100 -> rgb=000, hsync=0, vsync=0, frame_tick=0.
//     After release, box at (0,0): pix=(10,10) gives rgb=100 one clk later; pix=(40,10) gives 001.
//  2. Hold pix_y=480 for 10 clk after pix_y=479 -> frame_tick high exactly 1 clk.
//     With run=1, box_x=2 and box_y=2 after the pulse.
//  3. Bounce, run=1, 304 frame ticks -> box_x stops at 608 and dir_x flips to -.
//     Next tick: box_x=606.
//     Y: box_y clamps at 448 on tick 224, then decreases.
//  4. run=0 for 3 frames -> box position unchanged, frame_tick still pulses.
//     pix=(700,200) -> rgb=000 (blanking).
//  5. Assert reset during a visible line mid-motion -> next clk: outputs 0, box at (0,0), directions +.
//  6. With GRID_OVERLAY_EN: pix=(64,100) outside box -> rgb=010; pix=(65,101) -> 001.
//     Without the macro: pix=(64,100) -> 001.

Source files
------------

// File: rtl/vga_box_gen.sv
// Bouncing-square pixel generator stage behind vga_sync; colour and sync are registered together.
// Optional grid overlay is enabled by defining GRID_OVERLAY_EN.
module vga_box_gen #(
  parameter int         H_VIS      = 640,
  parameter int         V_VIS      = 480,
  parameter int         BOX_SIZE   = 32,
  parameter int         STEP       = 2,
  parameter logic [2:0] BOX_COLOR  = 3'b100,
  parameter logic [2:0] BG_COLOR   = 3'b001,
  parameter logic [2:0] GRID_COLOR = 3'b010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb,
  output logic       frame_tick
);

  localparam logic        DIR_POS = 1'b0;
  localparam logic        DIR_NEG = 1'b1;
  localparam logic [10:0] X_MAX   = 11'(H_VIS - BOX_SIZE);
  localparam logic [10:0] Y_MAX   = 11'(V_VIS - BOX_SIZE);
  localparam logic [10:0] STEP11  = 11'(STEP);
  localparam logic [10:0] SIZE11  = 11'(BOX_SIZE);
  localparam logic [9:0]  H_VIS10 = 10'(H_VIS);
  localparam logic [9:0]  V_VIS10 = 10'(V_VIS);

  logic [9:0] box_x, box_y;
  logic       dir_x, dir_y;
  logic       tick_c, tick_d;
  logic       video_on, in_box;
  logic [10:0] nxt_x, nxt_y;
  logic [2:0]  pix_color;

  // One axis of motion, widened to 11 bits; returns {next_dir, next_pos}.
  function automatic logic [10:0] step_axis(input logic [9:0] pos, input logic dir,
                                            input logic [10:0] lim);
    logic [10:0] pos11;
    logic [10:0] np;
    pos11 = {1'b0, pos};
    np    = pos11 + STEP11;
    if (dir == DIR_POS) begin
      if (np >= lim) step_axis = {DIR_NEG, lim[9:0]};
      else           step_axis = {DIR_POS, np[9:0]};
    end else begin
      if (pos11 <= STEP11) step_axis = {DIR_POS, 10'd0};
      else                 step_axis = {DIR_NEG, pos - STEP11[9:0]};
    end
  endfunction

  assign nxt_x    = step_axis(box_x, dir_x, X_MAX);
  assign nxt_y    = step_axis(box_y, dir_y, Y_MAX);
  assign tick_c   = (pix_y == V_VIS10);
  assign video_on = (pix_x < H_VIS10) && (pix_y < V_VIS10);
  assign in_box   = ({1'b0, pix_x} >= {1'b0, box_x}) && ({1'b0, pix_x} < {1'b0, box_x} + SIZE11) &&
                    ({1'b0, pix_y} >= {1'b0, box_y}) && ({1'b0, pix_y} < {1'b0, box_y} + SIZE11);

  always_comb begin
    pix_color = BG_COLOR;
    if (!video_on)   pix_color = 3'b000;
    else if (in_box) pix_color = BOX_COLOR;
`ifdef GRID_OVERLAY_EN
    else if (pix_x[4:0] == 5'd0 || pix_y[4:0] == 5'd0) pix_color = GRID_COLOR;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hsync      <= 1'b0;
      vsync      <= 1'b0;
      rgb        <= 3'b000;
      frame_tick <= 1'b0;
      tick_d     <= 1'b0;
      box_x      <= 10'd0;
      box_y      <= 10'd0;
      dir_x      <= DIR_POS;
      dir_y      <= DIR_POS;
    end else begin
      hsync      <= hsync_in;
      vsync      <= vsync_in;
      rgb        <= pix_color;
      tick_d     <= tick_c;
      frame_tick <= tick_c & ~tick_d;
      // frame_tick only rises in vertical blanking, so the box never moves mid-frame
      if (frame_tick && run) begin
        {dir_x, box_x} <= nxt_x;
        {dir_y, box_y} <= nxt_y;
      end
    end
  end

endmodule

// File: tb/tb_vga_box_gen.sv
// Directed bench for vga_box_gen: vector table for pixel colouring, hand sequences for motion and reset.
module tb_vga_box_gen;

  logic       clk = 1'b0;
  logic       reset, run, hsync_in, vsync_in;
  logic [9:0] pix_x, pix_y;
  logic       hsync, vsync, frame_tick;
  logic [2:0] rgb;

  int n_cmp = 0;
  int n_err = 0;

`ifdef GRID_OVERLAY_EN
  localparam logic [2:0] GRID_EXP = 3'b010;
`else
  localparam logic [2:0] GRID_EXP = 3'b001;
`endif

  vga_box_gen dut (
    .clk(clk), .reset(reset), .run(run), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .pix_x(pix_x), .pix_y(pix_y), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] x, y;
    logic       hs, vs;
    logic [2:0] exp_rgb;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic probe(input string name, input int x, input int y, input logic [2:0] exp);
    pix_x = 10'(x);
    pix_y = 10'(y);
    @(posedge clk); #1;
    chk(name, int'(rgb), int'(exp));
  endtask

  // Two clocks at pix_y==V_VIS then leave blanking; exactly one frame_tick expected.
  task automatic do_tick();
    int hits;
    hits  = 0;
    pix_x = 10'd0;
    pix_y = 10'd480;
    repeat (2) begin @(posedge clk); #1; hits += int'(frame_tick); end
    pix_y = 10'd0;
    @(posedge clk); #1;
    hits += int'(frame_tick);
    chk("frame_tick_once", hits, 1);
  endtask

  initial begin
    int hits;
    vecs[0]  = '{10'd10,   10'd10,   1'b1, 1'b0, 3'b100};
    vecs[1]  = '{10'd40,   10'd10,   1'b0, 1'b1, 3'b001};
    vecs[2]  = '{10'd0,    10'd0,    1'b1, 1'b1, 3'b100};
    vecs[3]  = '{10'd31,   10'd31,   1'b0, 1'b0, 3'b100};
    vecs[4]  = '{10'd32,   10'd31,   1'b1, 1'b0, GRID_EXP};
    vecs[5]  = '{10'd31,   10'd32,   1'b0, 1'b1, GRID_EXP};
    vecs[6]  = '{10'd639,  10'd479,  1'b1, 1'b1, 3'b001};
    vecs[7]  = '{10'd640,  10'd10,   1'b0, 1'b0, 3'b000};
    vecs[8]  = '{10'd10,   10'd480,  1'b1, 1'b0, 3'b000};
    vecs[9]  = '{10'd700,  10'd200,  1'b0, 1'b1, 3'b000};
    vecs[10] = '{10'd1023, 10'd1023, 1'b1, 1'b1, 3'b000};
    vecs[11] = '{10'd64,   10'd100,  1'b0, 1'b0, GRID_EXP};
    vecs[12] = '{10'd65,   10'd101,  1'b1, 1'b0, 3'b001};
    vecs[13] = '{10'd33,   10'd0,    1'b0, 1'b1, GRID_EXP};
    vecs[14] = '{10'd1,    10'd1,    1'b0, 1'b0, 3'b100};

    // reset state
    reset = 1'b1; run = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    pix_x = 10'd100; pix_y = 10'd100;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_rgb", int'(rgb), 0);
    chk("reset_hsync", int'(hsync), 0);
    chk("reset_vsync", int'(vsync), 0);
    chk("reset_frame_tick", int'(frame_tick), 0);
    reset = 1'b0;

    // colour table with box at (0,0), frozen
    for (int i = 0; i < 15; i++) begin
      pix_x = vecs[i].x; pix_y = vecs[i].y;
      hsync_in = vecs[i].hs; vsync_in = vecs[i].vs;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_rgb", i), int'(rgb), int'(vecs[i].exp_rgb));
      chk($sformatf("vec%0d_hsync", i), int'(hsync), int'(vecs[i].hs));
      chk($sformatf("vec%0d_vsync", i), int'(vsync), int'(vecs[i].vs));
    end
    hsync_in = 1'b0; vsync_in = 1'b0;

    // long blanking hold gives one pulse and one step
    run = 1'b1;
    pix_x = 10'd0; pix_y = 10'd479;
    @(posedge clk); #1;
    pix_y = 10'd480;
    hits = 0;
    repeat (10) begin @(posedge clk); #1; hits += int'(frame_tick); end
    chk("hold480_one_pulse", hits, 1);
    probe("step1_in_2_2", 2, 2, 3'b100);
    probe("step1_out_1_2", 1, 2, 3'b001);
    probe("step1_out_2_1", 2, 1, 3'b001);
    probe("step1_in_33_33", 33, 33, 3'b100);
    probe("step1_out_34_33", 34, 33, 3'b001);

    // bounce from origin
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (224) do_tick();
    probe("yclamp_in_448_448", 448, 448, 3'b100);
    probe("yclamp_out_449_447", 449, 447, 3'b001);
    probe("yclamp_in_479_479", 479, 479, 3'b100);
    do_tick();
    probe("ydown_in_450_446", 450, 446, 3'b100);
    probe("ydown_out_451_445", 451, 445, 3'b001);
    repeat (79) do_tick();
    probe("xclamp_in_608_290", 608, 290, 3'b100);
    probe("xclamp_out_607_290", 607, 290, 3'b001);
    probe("xclamp_in_639_319", 639, 319, 3'b100);
    do_tick();
    probe("xback_in_606_287", 606, 287, 3'b100);
    probe("xback_out_605_287", 605, 287, 3'b001);
    probe("xback_out_638_287", 638, 287, 3'b001);

    // frozen for three frames
    run = 1'b0;
    repeat (3) do_tick();
    probe("frozen_in_606_287", 606, 287, 3'b100);
    probe("frozen_out_605_287", 605, 287, 3'b001);
    probe("blank_700_200", 700, 200, 3'b000);

    // reset mid-motion on a visible line
    run = 1'b1;
    do_tick();
    hsync_in = 1'b1; vsync_in = 1'b1;
    pix_x = 10'd300; pix_y = 10'd300;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midreset_rgb", int'(rgb), 0);
    chk("midreset_hsync", int'(hsync), 0);
    chk("midreset_vsync", int'(vsync), 0);
    chk("midreset_frame_tick", int'(frame_tick), 0);
    reset = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    probe("midreset_in_0_0", 0, 0, 3'b100);
    probe("midreset_out_33_5", 33, 5, 3'b001);
    do_tick();
    probe("midreset_dir_in_2_2", 2, 2, 3'b100);
    probe("midreset_dir_out_1_2", 1, 2, 3'b001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
